// File: rtl/bnn_pkg.sv
// Shared sizing helpers for the binary neural network datapath.
// Beat count, address width and last-beat padding mask.
package bnn_pkg;

    localparam int MASK_MAX = 64;

    function automatic int beats(input int num_inputs, input int pw);
        return (num_inputs + pw - 1) / pw;
    endfunction

    function automatic int addr_w(input int n_beats);
        return (n_beats <= 1) ? 1 : $clog2(n_beats);
    endfunction

    // Ones on the REM real input bits; all ones when the vector fills the beat.
    function automatic logic [MASK_MAX-1:0] pad_mask(input int rem);
        logic [MASK_MAX-1:0] m;
        m = '1;
        if (rem != 0) begin
            m = (MASK_MAX'(1) << rem) - MASK_MAX'(1);
        end
        return m;
    endfunction

endpackage

// File: rtl/bnn_weight_ram.sv
// Simple dual-port weight store: synchronous write, registered read.
// Storage is never reset; only the read register is.
module bnn_weight_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/neuron_feeder.sv
// Per-neuron feeder: weight/threshold config plus aligned x/w beat stream.
// One-cycle latency from accepted input beat to neuron beat.
module neuron_feeder
    import bnn_pkg::*;
#(
    parameter int PW         = 16,
    parameter int THRESH_W   = 16,
    parameter int NUM_INPUTS = 784
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_w_en,
    input  logic [PW-1:0]       cfg_w_data,
    input  logic                cfg_t_en,
    input  logic [THRESH_W-1:0] cfg_t_data,
    output logic                cfg_ready,
    output logic                configured,
    input  logic [PW-1:0]       x_in,
    input  logic                x_in_valid,
    output logic                x_in_ready,
    output logic [PW-1:0]       x,
    output logic [PW-1:0]       w,
    output logic [THRESH_W-1:0] threshold,
    output logic                valid_in,
    output logic                last
);

    localparam int BEATS = beats(NUM_INPUTS, PW);
    localparam int REM   = NUM_INPUTS % PW;
    localparam int AW    = addr_w(BEATS);
    localparam logic [AW-1:0] LAST_A = AW'(BEATS - 1);
    localparam logic [MASK_MAX-1:0] MASK_FULL = pad_mask(REM);
    localparam logic [PW-1:0] MASK = MASK_FULL[PW-1:0];

    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_cnt;
    logic                r_w_loaded;
    logic                r_t_loaded;
    logic                r_cfgd;
    logic                r_up;
    logic [THRESH_W-1:0] r_thr;
    logic [PW-1:0]       r_x;
    logic                r_valid;
    logic                r_last;
    logic                r_pad;

    logic          w_cfg_ready;
    logic          w_wacc;
    logic          w_tacc;
    logic          w_xacc;
    logic          w_cnt_end;
    logic          w_wl_nxt;
    logic          w_tl_nxt;
    logic [PW-1:0] w_rd;

    assign w_cfg_ready = r_up && (r_cnt == '0) && !r_valid;
    assign w_wacc      = cfg_w_en && w_cfg_ready;
    assign w_tacc      = cfg_t_en && w_cfg_ready;
    assign x_in_ready  = r_cfgd && !w_wacc;
    assign w_xacc      = x_in_valid && x_in_ready;
    assign w_cnt_end   = (r_cnt == LAST_A);

    // Any write short of the wrap invalidates the weight vector.
    always_comb begin
        w_wl_nxt = r_w_loaded;
        if (w_wacc) begin
            w_wl_nxt = (r_wptr == LAST_A);
        end
        w_tl_nxt = r_t_loaded || w_tacc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_cnt      <= '0;
            r_w_loaded <= 1'b0;
            r_t_loaded <= 1'b0;
            r_cfgd     <= 1'b0;
            r_up       <= 1'b0;
            r_thr      <= '0;
            r_x        <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_pad      <= 1'b0;
        end else begin
            r_up       <= 1'b1;
            r_w_loaded <= w_wl_nxt;
            r_t_loaded <= w_tl_nxt;
            r_cfgd     <= w_wl_nxt && w_tl_nxt;
            r_valid    <= w_xacc;
            r_last     <= w_xacc && w_cnt_end;
            if (w_wacc) begin
                r_wptr <= (r_wptr == LAST_A) ? '0 : r_wptr + 1'b1;
            end
            if (w_tacc) begin
                r_thr <= cfg_t_data;
            end
            if (w_xacc) begin
                r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
                r_x   <= w_cnt_end ? (x_in & MASK) : x_in;
                r_pad <= w_cnt_end;
            end
        end
    end

    bnn_weight_ram #(
        .W     (PW),
        .DEPTH (BEATS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wacc),
        .i_waddr (r_wptr),
        .i_wdata (cfg_w_data),
        .i_re    (w_xacc),
        .i_raddr (r_cnt),
        .o_rdata (w_rd)
    );

    // Pad bits become x=0, w=1 so their XNOR never adds to the popcount.
    assign w          = w_rd | (r_pad ? ~MASK : '0);
    assign x          = r_x;
    assign threshold  = r_thr;
    assign valid_in   = r_valid;
    assign last       = r_last;
    assign cfg_ready  = w_cfg_ready;
    assign configured = r_cfgd;

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed plus randomized bench for neuron_feeder (PW=16, 40 inputs).
// Expected beats come from a vector-level reference model.
module tb_neuron_feeder;

    localparam int PW = 16;
    localparam int TW = 16;
    localparam int NI = 40;
    localparam int NB = (NI + PW - 1) / PW;
    localparam int RM = NI % PW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_w_en = 1'b0;
    logic [PW-1:0] cfg_w_data = '0;
    logic          cfg_t_en = 1'b0;
    logic [TW-1:0] cfg_t_data = '0;
    logic          cfg_ready;
    logic          configured;
    logic [PW-1:0] x_in = '0;
    logic          x_in_valid = 1'b0;
    logic          x_in_ready;
    logic [PW-1:0] x;
    logic [PW-1:0] w;
    logic [TW-1:0] threshold;
    logic          valid_in;
    logic          last;

    neuron_feeder #(.PW(PW), .THRESH_W(TW), .NUM_INPUTS(NI)) dut (
        .clk(clk), .rst(rst),
        .cfg_w_en(cfg_w_en), .cfg_w_data(cfg_w_data),
        .cfg_t_en(cfg_t_en), .cfg_t_data(cfg_t_data),
        .cfg_ready(cfg_ready), .configured(configured),
        .x_in(x_in), .x_in_valid(x_in_valid), .x_in_ready(x_in_ready),
        .x(x), .w(w), .threshold(threshold),
        .valid_in(valid_in), .last(last)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    logic [PW-1:0] m_mem [NB];
    int            m_wp, m_beat;
    bit            m_wl, m_tl, m_cfgd, m_up;
    logic [TW-1:0] m_thr;
    bit            m_valid, m_last;
    logic [PW-1:0] m_x, m_w;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wp = 0; m_beat = 0;
        m_wl = 0; m_tl = 0; m_cfgd = 0; m_up = 0;
        m_thr = '0; m_valid = 0; m_last = 0;
        m_x = '0; m_w = '0;
    endtask

    // Apply the current inputs across one clock edge and check the result.
    task automatic cyc();
        bit e_cr, e_xr, aw, at, ax, lastbeat;
        logic [PW-1:0] bx, bw;
        e_cr = m_up && m_beat == 0 && !m_valid;
        aw = cfg_w_en && e_cr;
        at = cfg_t_en && e_cr;
        e_xr = m_cfgd && !aw;
        ax = x_in_valid && e_xr;
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(e_cr));
        chk("x_in_ready", 32'(x_in_ready), 32'(e_xr));
        @(posedge clk);
        if (ax) begin
            lastbeat = (m_beat == NB - 1);
            bx = x_in;
            bw = m_mem[m_beat];
            if (lastbeat && RM != 0) begin
                for (int i = RM; i < PW; i++) begin
                    bx[i] = 1'b0;
                    bw[i] = 1'b1;
                end
            end
            m_x = bx; m_w = bw; m_last = lastbeat;
            m_beat = (m_beat + 1) % NB;
        end else begin
            m_last = 0;
        end
        m_valid = ax;
        if (aw) begin
            m_mem[m_wp] = cfg_w_data;
            m_wl = (m_wp == NB - 1);
            m_wp = (m_wp + 1) % NB;
        end
        if (at) begin
            m_thr = cfg_t_data;
            m_tl = 1;
        end
        m_cfgd = m_wl && m_tl;
        m_up = 1;
        #1;
        chk("valid_in", 32'(valid_in), 32'(m_valid));
        chk("last", 32'(last), 32'(m_last));
        chk("configured", 32'(configured), 32'(m_cfgd));
        chk("threshold", 32'(threshold), 32'(m_thr));
        chk("x", 32'(x), 32'(m_x));
        chk("w", 32'(w), 32'(m_w));
    endtask

    task automatic idle(input int n);
        cfg_w_en = 0; cfg_t_en = 0; x_in_valid = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr_w(input logic [PW-1:0] d);
        cfg_w_en = 1; cfg_w_data = d; cfg_t_en = 0; x_in_valid = 0;
        cyc();
        cfg_w_en = 0;
    endtask

    task automatic wr_t(input logic [TW-1:0] d);
        cfg_t_en = 1; cfg_t_data = d; cfg_w_en = 0; x_in_valid = 0;
        cyc();
        cfg_t_en = 0;
    endtask

    task automatic beat(input logic [PW-1:0] d);
        x_in_valid = 1; x_in = d; cfg_w_en = 0; cfg_t_en = 0;
        cyc();
        x_in_valid = 0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1;
        #1;
        chk("rst_valid", 32'(valid_in), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_configured", 32'(configured), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_threshold", 32'(threshold), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < NB; i++) m_mem[i] = '0;
        do_reset();
        chk("post_rst_x", 32'(x), 32'd0);
        chk("post_rst_w", 32'(w), 32'd0);
        m_up = 1;

        // Configuration with a beat offered before it is configured
        x_in = 16'h1111;
        x_in_valid = 1;
        cyc();
        wr_w(16'hAAAA); wr_w(16'h5555); wr_w(16'h00FF);
        wr_t(16'd20);
        idle(1);

        // Streaming vector
        beat(16'h1234); beat(16'hFFFF); beat(16'h00AB);
        idle(2);

        // Gapped vector straight into a second vector
        beat(16'($urandom)); idle(2);
        beat(16'($urandom)); idle(1);
        beat(16'($urandom));
        beat(16'($urandom)); beat(16'($urandom)); beat(16'($urandom));
        idle(1);

        // Write attempt mid-vector is dropped
        beat(16'($urandom));
        wr_w(16'hDEAD);
        beat(16'($urandom)); beat(16'($urandom));
        idle(1);

        // Reset after the second beat
        beat(16'($urandom)); beat(16'($urandom));
        do_reset();
        m_up = 1;
        wr_w(16'($urandom)); wr_w(16'($urandom)); wr_w(16'($urandom));
        wr_t(16'($urandom));
        for (int i = 0; i < NB; i++) beat(16'($urandom));
        idle(1);

        // Partial reload while configured
        wr_w(16'hC3C3);
        x_in = 16'h7777; x_in_valid = 1;
        cyc(); cyc();
        wr_w(16'($urandom));
        x_in_valid = 1;
        cyc();
        wr_w(16'($urandom));
        for (int i = 0; i < NB; i++) beat(16'($urandom));

        // Random traffic with config writes interleaved
        for (int i = 0; i < 300; i++) begin
            cfg_w_en   = ($urandom_range(0, 7) == 0);
            cfg_w_data = 16'($urandom);
            cfg_t_en   = ($urandom_range(0, 15) == 0);
            cfg_t_data = 16'($urandom);
            x_in_valid = ($urandom_range(0, 2) != 0);
            x_in       = 16'($urandom);
            cyc();
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Upstream stage of the neuron processor, one per neuron.
- Holds that neuron's weight RAM and threshold register, both loaded through a configuration port.
- Accepts an input activation vector as PW-bit beats with a valid/ready handshake.
- Emits aligned x/w/threshold/valid_in/last beats that the neuron consumes directly (no backpressure from the neuron).

Parameters:
- PW, 16: beat width in bits (x and w word width).
- THRESH_W, 16: threshold width.
- NUM_INPUTS, 784: input bits per vector. BEATS = ceil(NUM_INPUTS/PW); REM = NUM_INPUTS mod PW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_w_en  in  1  weight word write strobe
- cfg_w_data  in  PW  weight word, written sequentially from address 0
- cfg_t_en  in  1  threshold write strobe
- cfg_t_data  in  THRESH_W  threshold value
- cfg_ready  out  1  config writes accepted this cycle
- configured  out  1  all BEATS weight words and the threshold have been loaded
- x_in  in  PW  input activation beat
- x_in_valid  in  1  beat valid
- x_in_ready  out  1  beat accepted when valid&&ready
- x  out  PW  activation to neuron
- w  out  PW  weight to neuron
- threshold  out  THRESH_W  threshold to neuron
- valid_in  out  1  neuron beat valid
- last  out  1  final beat of vector

Behaviour:
- Reset (async assert, sync deassert): x, w, valid_in, last, threshold and configured = 0; cfg_ready = 1 from the first post-reset cycle; write pointer, beat counter and loaded flags = 0. RAM contents are not cleared, but a reload is mandatory because the flags are cleared. Reset mid-vector discards the partial vector, and no last is emitted.
- Config:
  - cfg_ready = 1 iff beat_cnt == 0 and no output beat is pending.
  - A cfg_w_en when cfg_ready = 0 is ignored.
  - An accepted weight write stores at wptr. wptr increments and wraps to 0 after BEATS-1, and that wrap sets w_loaded.
  - An accepted cfg_t_en loads the threshold register and sets t_loaded.
  - A cfg_w_en and cfg_t_en in the same cycle are both accepted.
  - configured = w_loaded && t_loaded (registered).
  - A new weight write while configured clears w_loaded until the next wrap, which reloads the whole vector.
- Input handshake:
  - x_in_ready = configured && (cfg_w_en == 0 || cfg_ready == 0).
  - A write and a beat are never accepted in the same cycle: a cfg_w_en issued while cfg_ready = 1 takes priority over x_in.
  - Each accepted beat issues a synchronous RAM read at address beat_cnt.
  - beat_cnt increments per accepted beat and wraps to 0 after BEATS-1.
- Output timing:
  - Exactly 1-cycle latency: accept at cycle N gives valid_in = 1 at N+1, with x and w from that beat.
  - last = 1 alongside the beat whose beat_cnt was BEATS-1.
  - Back-to-back beats give back-to-back valid_in.
  - x and w hold their previous values when valid_in = 0.
  - threshold is driven continuously from its register.
- Padding: if REM != 0, on the last beat bits [PW-1:REM] are forced to x = 0, w = 1, so XNOR = 0 and the neuron popcount counts only real inputs. Bit 0 is the first input of each beat.
- Single-beat vector (BEATS = 1): every accepted beat carries last = 1.

Decomposition:
- bnn_pkg holds:
  - function beats(num_inputs, pw);
  - the address width constant $clog2(BEATS) (minimum 1);
  - the padding-mask function returning a PW-bit mask for REM.
- One sub-module, bnn_weight_ram: simple dual-port, synchronous write, 1-cycle synchronous read, depth BEATS, width PW, inferred BRAM/LUTRAM, no reset on storage.

Test Plan (PW=16, NUM_INPUTS=40, so BEATS=3 and REM=8):
- Reset then config:
  - Stimulus: write weights 0xAAAA, 0x5555, 0x00FF, then threshold 20.
  - Required: configured rises 1 cycle after the last write; x_in_ready = 0 before that.
- Streaming vector:
  - Stimulus: x_in 0x1234, 0xFFFF, 0x00AB on consecutive cycles.
  - Required: valid_in high for 3 consecutive cycles starting 1 cycle later; w = 0xAAAA, 0x5555, 0x00FF; last only on the 3rd beat; 3rd x = 0x00AB, w = 0xFFFF after padding; threshold = 20.
- Gapped and back-to-back vectors:
  - Stimulus: insert idle cycles between beats, then start a second vector immediately after last.
  - Required: beat_cnt wraps; the second vector's first beat carries w = 0xAAAA and last = 0.
- Config blocked mid-vector:
  - Stimulus: after 1 beat, pulse cfg_w_en with 0xDEAD.
  - Required: cfg_ready = 0, the write is ignored, and the remaining w values are unchanged.
- Reset mid-vector:
  - Stimulus: assert rst after beat 2 with no clock edge.
  - Required: valid_in, last, configured and cfg_ready drop immediately and asynchronously (cfg_ready returns to 1 from the first post-reset cycle). After reload, the first beat has w = word 0.
- Partial reload:
  - Stimulus: write one weight word while configured.
  - Required: configured drops to 0 and x_in_ready = 0 until 2 more words are written.
